// File: rtl/sched_rr_4x4.sv
// sched_rr_4x4 - central scheduler for the 4-in/4-out 10-bit word switch.
//
// Sequences the system state machine (RESET/INIT/IDLE/ACTIVE/ERROR), latches
// the alto/bajo watermarks while in INIT, round-robin arbitrates the heads of
// input FIFOs 0..3 whose destination output FIFO is not almost-full, moves one
// word per cycle and keeps a wrapping word counter per destination.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   init                  request INIT (threshold programming)
//   alto_in, bajo_in      watermark values latched during INIT
//   alto_out, bajo_out    latched watermarks driven to all FIFOs
//   data_in0..data_in3    head words of input FIFOs 0..3 (first-word-fall-through)
//   empty_in              empty flags of input FIFOs 0..3
//   afull_out             almost-full flags of output FIFOs 4..7 (bit d = FIFO 4+d)
//   fifo_err              overflow/underflow flags of FIFOs 0..7
//   pop                   combinational pop strobes to input FIFOs 0..3
//   push, data_out        registered push strobes / word to output FIFOs 4..7
//   req, idx              counter read request and destination select
//   contador_out          counter read data (valid with valid_contador)
//   idle, active, error   state indicators
module sched_rr_4x4 #(
    parameter int WORD_W = 10,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [2:0]        alto_in,
    input  logic [2:0]        bajo_in,
    output logic [2:0]        alto_out,
    output logic [2:0]        bajo_out,
    input  logic [WORD_W-1:0] data_in0,
    input  logic [WORD_W-1:0] data_in1,
    input  logic [WORD_W-1:0] data_in2,
    input  logic [WORD_W-1:0] data_in3,
    input  logic [3:0]        empty_in,
    input  logic [3:0]        afull_out,
    input  logic [7:0]        fifo_err,
    output logic [3:0]        pop,
    output logic [3:0]        push,
    output logic [WORD_W-1:0] data_out,
    input  logic              req,
    input  logic [1:0]        idx,
    output logic [CNT_W-1:0]  contador_out,
    output logic              valid_contador,
    output logic              idle,
    output logic              active,
    output logic              error
);

    typedef enum logic [2:0] {
        S_RESET,
        S_INIT,
        S_IDLE,
        S_ACTIVE,
        S_ERROR
    } state_t;

    state_t            state;
    logic [1:0]        ptr;
    logic [CNT_W-1:0]  cnt [4];
    logic [WORD_W-1:0] din [4];

    logic [3:0]        elig;
    logic              gnt_vld;
    logic [1:0]        gnt;
    logic [1:0]        cand;
    logic [WORD_W-1:0] gnt_word;
    logic [1:0]        gnt_dest;

    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign din[2] = data_in2;
    assign din[3] = data_in3;

    // Round-robin search starting just after the last grant. No grant while
    // reset or init is asserted, so no word is popped in a cycle whose push
    // would be discarded or that leaves ACTIVE for INIT.
    always_comb begin
        elig    = '0;
        gnt_vld = 1'b0;
        gnt     = ptr;
        cand    = ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            elig[i] = !empty_in[i] && !afull_out[din[i][WORD_W-1 -: 2]];
        end
        if (state == S_ACTIVE && !reset && !init) begin
            for (int unsigned k = 1; k <= 4; k++) begin
                cand = ptr + 2'(k);
                if (!gnt_vld && elig[cand]) begin
                    gnt_vld = 1'b1;
                    gnt     = cand;
                end
            end
        end
    end

    assign gnt_word = din[gnt];
    assign gnt_dest = gnt_word[WORD_W-1 -: 2];
    assign pop      = gnt_vld ? (4'b0001 << gnt) : '0;

    assign idle   = (state == S_IDLE);
    assign active = (state == S_ACTIVE);
    assign error  = (state == S_ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_RESET;
            ptr            <= 2'd3;
            for (int unsigned d = 0; d < 4; d++) begin
                cnt[d] <= '0;
            end
            push           <= '0;
            data_out       <= '0;
            alto_out       <= 3'd6;
            bajo_out       <= 3'd1;
            valid_contador <= 1'b0;
            contador_out   <= '0;
        end else begin
            push           <= '0;
            valid_contador <= 1'b0;
            contador_out   <= '0;

            if (gnt_vld) begin
                push     <= 4'b0001 << gnt_dest;
                data_out <= gnt_word;
                ptr      <= gnt;
            end

            // Count on the registered push, so an in-flight word that lands
            // in the first ERROR cycle is still counted.
            for (int unsigned d = 0; d < 4; d++) begin
                if (push[d]) begin
                    cnt[d] <= cnt[d] + 1'b1;
                end
            end

            if (state == S_IDLE && req) begin
                valid_contador <= 1'b1;
                contador_out   <= cnt[idx];
            end

            case (state)
                S_RESET: state <= S_INIT;
                S_ERROR: state <= S_ERROR;
                default: begin
                    if (|fifo_err) begin
                        state <= S_ERROR;
                    end else if (init) begin
                        state <= S_INIT;
                        if (state == S_INIT) begin
                            alto_out <= alto_in;
                            bajo_out <= bajo_in;
                        end
                    end else if (state == S_INIT) begin
                        state <= S_IDLE;
                    end else if (empty_in == 4'hF) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_ACTIVE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sched_rr_4x4.sv
module tb_sched_rr_4x4;

    localparam int W  = 10;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset, init;
    logic [2:0]    alto_in, bajo_in, alto_out, bajo_out;
    logic [W-1:0]  din [4];
    logic [3:0]    empty_in, afull_out;
    logic [7:0]    fifo_err;
    logic [3:0]    pop, push;
    logic [W-1:0]  data_out;
    logic          req;
    logic [1:0]    idx;
    logic [CW-1:0] contador_out;
    logic          valid_contador, idle, active, error;

    always #5 clk = ~clk;

    sched_rr_4x4 #(.WORD_W(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .init(init),
        .alto_in(alto_in), .bajo_in(bajo_in),
        .alto_out(alto_out), .bajo_out(bajo_out),
        .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
        .empty_in(empty_in), .afull_out(afull_out), .fifo_err(fifo_err),
        .pop(pop), .push(push), .data_out(data_out),
        .req(req), .idx(idx), .contador_out(contador_out),
        .valid_contador(valid_contador),
        .idle(idle), .active(active), .error(error)
    );

    typedef enum int {M_RESET, M_INIT, M_IDLE, M_ACTIVE, M_ERROR} mst_t;

    // One scoreboard entry per cycle: what the registered outputs must show
    // in the following cycle.
    typedef struct {
        logic          v;
        logic [1:0]    d;
        logic [W-1:0]  w;
        logic          rv;
        logic [CW-1:0] rc;
    } exp_t;

    exp_t         sb [$];
    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];
    logic [W-1:0] q2 [$];
    logic [W-1:0] q3 [$];

    mst_t       mst;
    int         mptr;
    int         mcnt [4];
    logic [2:0] malto, mbajo;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] dst(input logic [W-1:0] w);
        return w[W-1:W-2];
    endfunction

    task automatic qpush(input int i, input logic [W-1:0] w);
        case (i)
            0: q0.push_back(w);
            1: q1.push_back(w);
            2: q2.push_back(w);
            default: q3.push_back(w);
        endcase
    endtask

    task automatic drive();
        empty_in[0] = (q0.size() == 0); din[0] = (q0.size() != 0) ? q0[0] : '0;
        empty_in[1] = (q1.size() == 0); din[1] = (q1.size() != 0) ? q1[0] : '0;
        empty_in[2] = (q2.size() == 0); din[2] = (q2.size() != 0) ? q2[0] : '0;
        empty_in[3] = (q3.size() == 0); din[3] = (q3.size() != 0) ? q3[0] : '0;
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            exp_t       e, ne;
            int         g;
            logic [3:0] epop, popped;
            mst_t       nx;
            logic       lat;

            @(negedge clk);
            g = -1;
            if (mst == M_ACTIVE && !reset && !init) begin
                for (int k = 1; k <= 4; k++) begin
                    int i;
                    i = (mptr + k) % 4;
                    if (g < 0 && !empty_in[i] && !afull_out[dst(din[i])]) g = i;
                end
            end
            epop = (g >= 0) ? 4'(1 << g) : 4'h0;
            chk("pop", 32'(pop), 32'(epop));

            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard: observed empty expected one entry");
                e.v = 1'b0; e.d = '0; e.w = '0; e.rv = 1'b0; e.rc = '0;
            end else begin
                e = sb.pop_front();
            end
            chk("push", 32'(push), e.v ? 32'(1 << e.d) : 32'd0);
            if (e.v) chk("data_out", 32'(data_out), 32'(e.w));
            chk("valid_contador", 32'(valid_contador), 32'(e.rv));
            chk("contador_out", 32'(contador_out), 32'(e.rc));
            chk("idle", 32'(idle), 32'(mst == M_IDLE));
            chk("active", 32'(active), 32'(mst == M_ACTIVE));
            chk("error", 32'(error), 32'(mst == M_ERROR));
            chk("alto_out", 32'(alto_out), 32'(malto));
            chk("bajo_out", 32'(bajo_out), 32'(mbajo));

            ne.v  = (g >= 0);
            ne.d  = (g >= 0) ? dst(din[g]) : 2'd0;
            ne.w  = (g >= 0) ? din[g] : '0;
            ne.rv = (mst == M_IDLE) && req && !reset;
            ne.rc = ne.rv ? CW'(mcnt[idx]) : '0;
            sb.push_back(ne);
            if (e.v) mcnt[e.d] = (mcnt[e.d] + 1) % 32;
            popped = pop;

            nx = mst;
            if (reset) nx = M_RESET;
            else if (mst == M_RESET) nx = M_INIT;
            else if (mst != M_ERROR) begin
                if (|fifo_err) nx = M_ERROR;
                else if (init) nx = M_INIT;
                else if (mst == M_INIT) nx = M_IDLE;
                else nx = (empty_in == 4'hF) ? M_IDLE : M_ACTIVE;
            end
            lat = !reset && mst == M_INIT && !(|fifo_err) && init;

            @(posedge clk);
            mst = nx;
            if (reset) begin
                mptr = 3; malto = 3'd6; mbajo = 3'd1;
                for (int d = 0; d < 4; d++) mcnt[d] = 0;
            end else begin
                if (g >= 0) mptr = g;
                if (lat) begin malto = alto_in; mbajo = bajo_in; end
            end
            if (popped[0] && q0.size() != 0) q0.delete(0);
            if (popped[1] && q1.size() != 0) q1.delete(0);
            if (popped[2] && q2.size() != 0) q2.delete(0);
            if (popped[3] && q3.size() != 0) q3.delete(0);
            #1;
            drive();
        end
    endtask

    task automatic do_reset_init();
        reset = 1'b1;
        step(2);
        reset = 1'b0; init = 1'b1; alto_in = 3'd5; bajo_in = 3'd3;
        step(2);
        init = 1'b0;
        step(2);
    endtask

    initial begin
        exp_t e0;
        reset = 1'b1; init = 1'b0; alto_in = '0; bajo_in = '0;
        afull_out = '0; fifo_err = '0; req = 1'b0; idx = '0;
        drive();
        @(posedge clk);
        #1;
        mst = M_RESET; mptr = 3; malto = 3'd6; mbajo = 3'd1;
        for (int d = 0; d < 4; d++) mcnt[d] = 0;
        e0.v = 1'b0; e0.d = '0; e0.w = '0; e0.rv = 1'b0; e0.rc = '0;
        sb.push_back(e0);

        // Reset state, then two-cycle INIT programming 5/3.
        step(1);
        reset = 1'b0; init = 1'b1; alto_in = 3'd2; bajo_in = 3'd4;
        step(2);
        alto_in = 3'd5; bajo_in = 3'd3;
        step(1);
        init = 1'b0; alto_in = 3'd7; bajo_in = 3'd7;
        step(1);
        chk("t1_alto", 32'(alto_out), 32'd5);
        chk("t1_bajo", 32'(bajo_out), 32'd3);
        chk("t1_idle", 32'(idle), 32'd1);
        step(1);

        // Four words into FIFO0, then counter read of dest 0.
        for (int i = 0; i < 4; i++) qpush(0, 10'h001);
        drive();
        step(7);
        req = 1'b1; idx = 2'd0;
        step(1);
        req = 1'b0;
        chk("t2_valid", 32'(valid_contador), 32'd1);
        chk("t2_cnt0", 32'(contador_out), 32'd4);
        step(1);

        // All four inputs busy, one word per destination each round.
        do_reset_init();
        for (int r = 0; r < 2; r++) begin
            qpush(0, 10'h001 + 10'(r));
            qpush(1, 10'h101 + 10'(r));
            qpush(2, 10'h201 + 10'(r));
            qpush(3, 10'h301 + 10'(r));
        end
        drive();
        step(12);
        chk("t3_last_word", 32'(data_out), 32'h302);

        // Dest 1 almost full: only input 1 (dest 2) is served, then release.
        afull_out = 4'b0010;
        qpush(0, 10'h1A0); qpush(0, 10'h1A1);
        qpush(1, 10'h2B0);
        qpush(2, 10'h1C0); qpush(2, 10'h1C1);
        drive();
        step(5);
        chk("t4_blocked_word", 32'(data_out), 32'h2B0);
        afull_out = 4'b0000;
        step(7);
        chk("t4_last_word", 32'(data_out), 32'h1A1);

        // 33 words to dest 3: counter wraps to 1.
        do_reset_init();
        for (int i = 0; i < 33; i++) qpush(3, 10'h300 + 10'(i));
        drive();
        step(37);
        req = 1'b1; idx = 2'd3;
        step(1);
        req = 1'b0;
        chk("t5_valid", 32'(valid_contador), 32'd1);
        chk("t5_cnt3_wrap", 32'(contador_out), 32'd1);
        step(1);

        // fifo_err[5] in ACTIVE: sticky ERROR until reset.
        for (int i = 0; i < 6; i++) qpush(0, 10'h0E0 + 10'(i));
        drive();
        step(3);
        fifo_err = 8'h20;
        step(1);
        fifo_err = 8'h00;
        chk("t6_error", 32'(error), 32'd1);
        step(3);
        init = 1'b1;
        step(2);
        init = 1'b0;
        chk("t6_error_sticky", 32'(error), 32'd1);
        req = 1'b1; idx = 2'd0;
        step(1);
        req = 1'b0;
        chk("t6_no_read", 32'(valid_contador), 32'd0);
        reset = 1'b1;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        drive();
        step(1);
        reset = 1'b0;
        step(1);
        chk("t6_error_cleared", 32'(error), 32'd0);
        step(2);
        chk("t6_idle_again", 32'(idle), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
